pixel_point_op_stream: RTL

//  Multi-channel, parametrised pixel point-operation engine for the image pipeline.

---
 rtl/pixel_point_op_stream.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pixel_point_op_stream.sv
// Per-channel pixel point operations (add/sub/thresh/invert/gain/band/bypass), saturating.
// Latency 2 clk (stage 1 raw result, stage 2 saturate); 1 beat/clk throughput.
// Backpressure: s_ready = ~m_valid | m_ready; whole pipe freezes on stall, no bubbles, no drops.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cfg_mode/value/thresh/gain         operation config, captured when pixel 0 of a frame is accepted
//   s_valid/s_ready/s_data             input stream, channel c at [c*PIX_W +: PIX_W]
//   m_valid/m_ready/m_data/m_last      output stream, m_last marks pixel FRAME_PIX-1
//   frame_cnt                          completed frames (wraps)
module pixel_point_op_stream #(
   parameter int PIX_W     = 8,
   parameter int CH        = 3,
   parameter int FRAME_PIX = 32768,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            cfg_mode,
   input  logic [PIX_W-1:0]      cfg_value,
   input  logic [PIX_W-1:0]      cfg_thresh,
   input  logic [7:0]            cfg_gain,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [CH*PIX_W-1:0]   s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CH*PIX_W-1:0]   m_data,
   output logic                  m_last,
   output logic [CNT_W-1:0]      frame_cnt
);

   // Widest raw result is the gain path: (PIX_W+8)-bit product >> 4.
   localparam int RAW_W  = PIX_W + 4;
   localparam int PROD_W = PIX_W + 8;
   localparam int PC_W   = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
   localparam logic [PC_W-1:0]  LAST_IDX = PC_W'(FRAME_PIX - 1);
   localparam logic [PIX_W-1:0] PIX_MAX  = '1;

   typedef enum logic [2:0] {
      MODE_ADD    = 3'b000,
      MODE_SUB    = 3'b001,
      MODE_THRESH = 3'b010,
      MODE_INV    = 3'b011,
      MODE_GAIN   = 3'b100,
      MODE_BAND   = 3'b101,
      MODE_BYP0   = 3'b110,
      MODE_BYP1   = 3'b111
   } mode_e;

   // Frame-level configuration shadow
   mode_e              mode_q;
   logic [PIX_W-1:0]   value_q, thresh_q;
   logic [7:0]         gain_q;

   // Pipeline state
   logic                 v1_q;
   logic [CH*RAW_W-1:0]  raw1_q, raw1_d;
   logic                 m_valid_q;
   logic [CH*PIX_W-1:0]  m_data_q, m_data_d;

   // Counters
   logic [PC_W-1:0]   in_cnt_q, out_cnt_q;
   logic [CNT_W-1:0]  frame_cnt_q;

   logic en, acc, dlv, first_beat;
   mode_e            eff_mode;
   logic [PIX_W-1:0] eff_value, eff_thresh;
   logic [7:0]       eff_gain;

   logic [PIX_W-1:0]  p;
   logic [PIX_W:0]    sum;
   logic [PROD_W-1:0] prod;
   logic [RAW_W-1:0]  raw, r2;

   assign en      = ~m_valid_q | m_ready;
   assign s_ready = en;
   assign acc     = s_valid & en;
   assign dlv     = m_valid_q & m_ready;

   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   // Combinational from held state, so it stays up through a stall.
   assign m_last    = m_valid_q & (out_cnt_q == LAST_IDX);
   assign frame_cnt = frame_cnt_q;

   // Pixel 0 is computed on the same edge that captures the shadow,
   // so it must see the live cfg inputs rather than the old shadow.
   always_comb begin
      first_beat = (in_cnt_q == '0);
      eff_mode   = first_beat ? mode_e'(cfg_mode) : mode_q;
      eff_value  = first_beat ? cfg_value  : value_q;
      eff_thresh = first_beat ? cfg_thresh : thresh_q;
      eff_gain   = first_beat ? cfg_gain   : gain_q;
   end

   // Stage 1: raw (unsaturated-high) result per channel; sub already floors at 0.
   always_comb begin
      raw1_d = '0;
      p      = '0;
      sum    = '0;
      prod   = '0;
      raw    = '0;
      for (int c = 0; c < CH; c++) begin
         p    = s_data[c*PIX_W +: PIX_W];
         sum  = {1'b0, p} + {1'b0, eff_value};
         prod = PROD_W'(p) * PROD_W'(eff_gain);
         case (eff_mode)
            MODE_ADD:    raw = RAW_W'(sum);
            MODE_SUB:    raw = (p >= eff_value) ? RAW_W'(p - eff_value) : '0;
            MODE_THRESH: raw = (p > eff_thresh) ? RAW_W'(PIX_MAX) : '0;
            MODE_INV:    raw = RAW_W'(PIX_MAX - p);
            MODE_GAIN:   raw = RAW_W'(prod >> 4);
            MODE_BAND:   raw = (p >= eff_value && p <= eff_thresh) ? RAW_W'(p) : '0;
            default:     raw = RAW_W'(p);
         endcase
         raw1_d[c*RAW_W +: RAW_W] = raw;
      end
   end

   // Stage 2: clamp to PIX_MAX.
   always_comb begin
      m_data_d = '0;
      r2       = '0;
      for (int c = 0; c < CH; c++) begin
         r2 = raw1_q[c*RAW_W +: RAW_W];
         m_data_d[c*PIX_W +: PIX_W] = (r2 > RAW_W'(PIX_MAX)) ? PIX_MAX : r2[PIX_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q      <= 1'b0;
         raw1_q    <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
      end else if (en) begin
         v1_q      <= s_valid;
         raw1_q    <= raw1_d;
         m_valid_q <= v1_q;
         if (v1_q) m_data_q <= m_data_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_cnt_q <= '0;
         mode_q   <= MODE_ADD;
         value_q  <= '0;
         thresh_q <= '0;
         gain_q   <= '0;
      end else if (acc) begin
         in_cnt_q <= (in_cnt_q == LAST_IDX) ? '0 : in_cnt_q + PC_W'(1);
         if (first_beat) begin
            mode_q   <= mode_e'(cfg_mode);
            value_q  <= cfg_value;
            thresh_q <= cfg_thresh;
            gain_q   <= cfg_gain;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_cnt_q   <= '0;
         frame_cnt_q <= '0;
      end else if (dlv) begin
         if (out_cnt_q == LAST_IDX) begin
            out_cnt_q   <= '0;
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
         end else begin
            out_cnt_q <= out_cnt_q + PC_W'(1);
         end
      end
   end

endmodule
